// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding, ACK/NACK bus levels and a
// constant clog2 helper for sizing the register pointer.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEVADR,
    ST_DEVACK,
    ST_REGADR,
    ST_REGACK,
    ST_WRDATA,
    ST_WRACK,
    ST_RDDATA,
    ST_RDACK,
    ST_WAIT
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/i2c_line_cond.sv
// Conditions one I2C pad: 2-FF synchroniser, optional 3-sample majority filter
// (I2C_GLITCH_FILTER_EN) and rise/fall detection on the conditioned level.
module i2c_line_cond (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic       filt;
  logic       prev;

  // Idle bus level is high, so everything resets to 1 to avoid phantom edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], pad};
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 3'b111;
      filt <= 1'b1;
    end else begin
      hist <= {hist[1:0], sync[1]};
      filt <= (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    end
  end
`else
  assign filt = sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= filt;
  end

  assign lvl  = filt;
  assign rise = filt & ~prev;
  assign fall = ~filt & prev;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing an NREG x 8-bit register file with burst access, pointer
// auto-increment and a write notify strobe. Optional macro: I2C_GLITCH_FILTER_EN.
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         NREG     = 8,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic                     clk_50M,
  input  logic                     rst_n,
  inout  wire                      Pad_SDA,
  inout  wire                      Pad_SCL,
  output logic [NREG*8-1:0]        regs_o,
  output logic                     wr_stb_o,
  output logic [clog2(NREG)-1:0]   wr_addr_o,
  output logic [7:0]               wr_data_o,
  output logic                     busy_o
);

  localparam int AW = clog2(NREG);

  i2c_state_e    state, state_n;
  logic          sda_lvl, sda_rise, sda_fall;
  logic          scl_lvl, scl_rise, scl_fall;
  logic          start_det, stop_det;
  logic [3:0]    bit_cnt;
  logic          byte_full;
  logic [7:0]    rx_sr;
  logic [7:0]    wr_byte;
  logic [6:0]    tx_rem;
  logic [AW-1:0] ptr;
  logic [7:0]    regs [NREG];
  logic          sda_bit, sda_bit_n;
  logic          bit_clr, bit_inc, rx_shift, wr_en;
  logic          ptr_ld, ptr_inc, tx_load, tx_shift;
  logic          busy_set, busy_clr;

  i2c_line_cond u_sda (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .pad   (Pad_SDA),
    .lvl   (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_line_cond u_scl (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .pad   (Pad_SCL),
    .lvl   (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  // Open-drain: only ever pull low or release.
  assign Pad_SDA = sda_bit ? 1'bz : 1'b0;
  assign Pad_SCL = 1'bz;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign byte_full = (bit_cnt == 4'd8);
  assign wr_byte   = {rx_sr[6:0], sda_lvl};

  for (genvar i = 0; i < NREG; i++) begin : g_flat
    assign regs_o[8*i +: 8] = regs[i];
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Byte phases advance on SCL fall once 8 bits are in, so SDA only changes with SCL low.
  always_comb begin
    state_n   = state;
    sda_bit_n = sda_bit;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    rx_shift  = 1'b0;
    wr_en     = 1'b0;
    ptr_ld    = 1'b0;
    ptr_inc   = 1'b0;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    busy_set  = 1'b0;
    busy_clr  = 1'b0;
    if (stop_det) begin
      state_n   = ST_IDLE;
      sda_bit_n = NACK;
      busy_clr  = 1'b1;
    end else if (start_det) begin
      state_n   = ST_DEVADR;
      sda_bit_n = NACK;
      bit_clr   = 1'b1;
    end else begin
      unique case (state)
        ST_DEVADR, ST_REGADR, ST_WRDATA: begin
          if (scl_rise) begin
            rx_shift = 1'b1;
            bit_inc  = 1'b1;
            wr_en    = (state == ST_WRDATA) && (bit_cnt == 4'd7);
          end else if (scl_fall && byte_full) begin
            sda_bit_n = ACK;
            if (state == ST_DEVADR) begin
              if (rx_sr[7:1] == DEV_ADDR) begin
                state_n  = ST_DEVACK;
                busy_set = 1'b1;
              end else begin
                state_n   = ST_WAIT;
                sda_bit_n = NACK;
              end
            end else if (state == ST_REGADR) begin
              state_n = ST_REGACK;
              ptr_ld  = 1'b1;
            end else begin
              state_n = ST_WRACK;
            end
          end
        end
        ST_DEVACK: begin
          if (scl_fall) begin
            bit_clr = 1'b1;
            if (rx_sr[0]) begin
              state_n   = ST_RDDATA;
              tx_load   = 1'b1;
              sda_bit_n = regs[ptr][7];
            end else begin
              state_n   = ST_REGADR;
              sda_bit_n = NACK;
            end
          end
        end
        ST_REGACK, ST_WRACK: begin
          if (scl_fall) begin
            state_n   = ST_WRDATA;
            bit_clr   = 1'b1;
            sda_bit_n = NACK;
          end
        end
        ST_RDDATA: begin
          if (scl_rise) begin
            bit_inc = 1'b1;
          end else if (scl_fall) begin
            if (byte_full) begin
              state_n   = ST_RDACK;
              ptr_inc   = 1'b1;
              sda_bit_n = NACK;
            end else begin
              tx_shift  = 1'b1;
              sda_bit_n = tx_rem[6];
            end
          end
        end
        ST_RDACK: begin
          if (scl_rise) begin
            rx_shift = 1'b1;
          end else if (scl_fall) begin
            if (rx_sr[0] == NACK) begin
              state_n   = ST_WAIT;
              sda_bit_n = NACK;
            end else begin
              state_n   = ST_RDDATA;
              tx_load   = 1'b1;
              bit_clr   = 1'b1;
              sda_bit_n = regs[ptr][7];
            end
          end
        end
        default: sda_bit_n = NACK;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sda_bit   <= 1'b1;
      bit_cnt   <= 4'd0;
      ptr       <= '0;
      wr_stb_o  <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= 8'h00;
      busy_o    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= RST_VAL;
    end else begin
      sda_bit  <= sda_bit_n;
      wr_stb_o <= 1'b0;
      if (bit_clr)      bit_cnt <= 4'd0;
      else if (bit_inc) bit_cnt <= bit_cnt + 4'd1;
      if (ptr_ld)                 ptr <= rx_sr[AW-1:0];
      else if (ptr_inc || wr_en)  ptr <= ptr + 1'b1;
      if (wr_en) begin
        regs[ptr] <= wr_byte;
        wr_stb_o  <= 1'b1;
        wr_addr_o <= ptr;
        wr_data_o <= wr_byte;
      end
      if (busy_set)      busy_o <= 1'b1;
      else if (busy_clr) busy_o <= 1'b0;
    end
  end

  // Shift registers carry data only; their contents are qualified by the FSM.
  always_ff @(posedge clk_50M) begin
    if (rx_shift) rx_sr <= wr_byte;
    if (tx_load)       tx_rem <= regs[ptr][6:0];
    else if (tx_shift) tx_rem <= {tx_rem[5:0], 1'b1};
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, table vectors, hand sequences
// and random transactions against a transaction-level register/pointer model.
module tb_i2c_target_regfile;

  localparam int         NREG    = 8;
  localparam int         AW      = 3;
  localparam logic [6:0] DEV     = 7'h50;
  localparam logic [7:0] RST_VAL = 8'h00;
  localparam int         Q       = 100;

  logic              clk_50M = 1'b0;
  logic              rst_n   = 1'b0;
  logic              m_sda   = 1'b1;
  logic              m_scl   = 1'b1;
  wire               sda_bus;
  wire               scl_bus;
  logic [NREG*8-1:0] regs_o;
  logic              wr_stb_o;
  logic [AW-1:0]     wr_addr_o;
  logic [7:0]        wr_data_o;
  logic              busy_o;

  assign sda_bus = m_sda ? 1'bz : 1'b0;
  assign scl_bus = m_scl ? 1'bz : 1'b0;
  pullup (sda_bus);
  pullup (scl_bus);

  always #10 clk_50M = ~clk_50M;

  i2c_target_regfile #(.DEV_ADDR(DEV), .NREG(NREG), .RST_VAL(RST_VAL)) dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .Pad_SDA   (sda_bus),
    .Pad_SCL   (scl_bus),
    .regs_o    (regs_o),
    .wr_stb_o  (wr_stb_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .busy_o    (busy_o)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [10:0] got_stb [1024];
  int          stb_n    = 0;
  int          stb_rd   = 0;
  int          busy_cnt = 0;
  logic [10:0] exp_stb [$];
  logic [7:0]  model [NREG];
  int          mptr;
  logic [7:0]  wq [$];

  always @(negedge clk_50M) begin
    if (wr_stb_o) begin
      got_stb[stb_n % 1024] <= {wr_addr_o, wr_data_o};
      stb_n <= stb_n + 1;
    end
    if (busy_o) busy_cnt <= busy_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < NREG; i++) f[8*i +: 8] = model[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model[i] = RST_VAL;
    mptr = 0;
    exp_stb.delete();
  endtask

  task automatic bit_w(input logic b, input logic glitch);
    m_sda = b; #Q;
    m_scl = 1'b1; #Q; #Q;
    m_scl = 1'b0;
    if (glitch) begin
      #(Q/2); m_scl = 1'b1; #15; m_scl = 1'b0; #(Q/2 - 15);
    end else begin
      #Q;
    end
  endtask

  task automatic bit_r(output logic b);
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    b = sda_bus; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b0; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #Q;
    m_scl = 1'b1; #Q;
    m_sda = 1'b1; #Q; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, input int glitch_bit);
    for (int i = 7; i >= 0; i--) bit_w(b[i], (7 - i) == glitch_bit);
    bit_r(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_r(b);
      d[i] = b;
    end
    bit_w(ack, 1'b0);
  endtask

  task automatic do_write(input logic [6:0] dev, input logic [7:0] ra, input logic exp_nack,
                          input int glitch_bit);
    logic a;
    logic [AW-1:0] pa;
    i2c_start();
    send_byte({dev, 1'b0}, a, -1);
    chk("dev_ack", a, exp_nack);
    if (!exp_nack) begin
      send_byte(ra, a, -1);
      chk("reg_ack", a, 0);
      mptr = ra % NREG;
      foreach (wq[i]) begin
        send_byte(wq[i], a, glitch_bit);
        chk("data_ack", a, 0);
        model[mptr] = wq[i];
        pa = mptr[AW-1:0];
        exp_stb.push_back({pa, wq[i]});
        mptr = (mptr + 1) % NREG;
      end
    end
    i2c_stop();
  endtask

  task automatic check_stb(input string name);
    chk({name, "_stb_cnt"}, stb_n - stb_rd, exp_stb.size());
    for (int i = 0; i < exp_stb.size(); i++) begin
      if (stb_rd + i < stb_n) chk({name, "_stb"}, got_stb[(stb_rd + i) % 1024], exp_stb[i]);
    end
    stb_rd = stb_n;
    exp_stb.delete();
    chk({name, "_regs"}, regs_o, model_flat());
  endtask

  task automatic do_read(input logic with_addr, input logic [7:0] ra, input int n);
    logic a;
    logic [7:0] d;
    i2c_start();
    if (with_addr) begin
      send_byte({DEV, 1'b0}, a, -1);
      chk("rd_devw_ack", a, 0);
      send_byte(ra, a, -1);
      chk("rd_reg_ack", a, 0);
      mptr = ra % NREG;
      i2c_start();
    end
    send_byte({DEV, 1'b1}, a, -1);
    chk("rd_devr_ack", a, 0);
    for (int i = 0; i < n; i++) begin
      recv_byte(d, i == n - 1);
      chk("rd_data", d, model[mptr]);
      mptr = (mptr + 1) % NREG;
    end
    #Q;
    chk("rd_sda_released", sda_bus, 1'b1);
    i2c_stop();
  endtask

  typedef struct {
    logic [6:0] dev;
    logic [7:0] ra;
    logic [7:0] data;
    logic       exp_nack;
    logic       exp_busy;
  } vec_t;

  initial begin
    vec_t vt [6];
    int   b0;
    int   op;
    int   n;
    logic a;
    logic b;

    vt[0] = '{7'h50, 8'h03, 8'hA5, 1'b0, 1'b1};
    vt[1] = '{7'h51, 8'h04, 8'h77, 1'b1, 1'b0};
    vt[2] = '{7'h50, 8'h04, 8'h3C, 1'b0, 1'b1};
    vt[3] = '{7'h50, 8'h0F, 8'hC3, 1'b0, 1'b1};
    vt[4] = '{7'h10, 8'h01, 8'hFF, 1'b1, 1'b0};
    vt[5] = '{7'h50, 8'h80, 8'h5E, 1'b0, 1'b1};

    model_reset();
    #53;
    chk("rst_sda", sda_bus, 1'b1);
    chk("rst_regs", regs_o, model_flat());
    chk("rst_stb", wr_stb_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_wr_addr", wr_addr_o, 0);
    chk("rst_wr_data", wr_data_o, 0);
    rst_n = 1'b1;
    #(2*Q);

    for (int i = 0; i < 6; i++) begin
      b0 = busy_cnt;
      wq = '{vt[i].data};
      do_write(vt[i].dev, vt[i].ra, vt[i].exp_nack, -1);
      chk("vec_busy", busy_cnt != b0, vt[i].exp_busy);
      check_stb("vec");
      if (i == 0) chk("t1_reg3", regs_o[31:24], 8'hA5);
    end

    wq = '{8'h11, 8'h22, 8'h33};
    do_write(DEV, 8'h06, 1'b0, -1);
    check_stb("burst");
    chk("burst_reg6", regs_o[55:48], 8'h11);
    chk("burst_reg7", regs_o[63:56], 8'h22);
    chk("burst_reg0", regs_o[7:0], 8'h33);

    do_read(1'b1, 8'h02, 3);

    // START after 4 data bits: partial byte must be dropped.
    i2c_start();
    send_byte({DEV, 1'b0}, a, -1);
    chk("abort_dev_ack", a, 0);
    send_byte(8'h05, a, -1);
    chk("abort_reg_ack", a, 0);
    for (int i = 0; i < 4; i++) bit_w(1'b1, 1'b0);
    wq = '{8'h99};
    i2c_start();
    send_byte({DEV, 1'b0}, a, -1);
    chk("abort2_dev_ack", a, 0);
    send_byte(8'h01, a, -1);
    chk("abort2_reg_ack", a, 0);
    send_byte(8'h99, a, -1);
    chk("abort2_data_ack", a, 0);
    i2c_stop();
    model[1] = 8'h99;
    exp_stb.push_back({3'd1, 8'h99});
    mptr = 2;
    check_stb("abort");

    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 2);
      n  = $urandom_range(1, 4);
      if (op == 0) begin
        wq.delete();
        for (int k = 0; k < n; k++) wq.push_back(8'($urandom_range(0, 255)));
        do_write(DEV, 8'($urandom_range(0, 255)), 1'b0, -1);
        check_stb("rnd_wr");
      end else begin
        do_read(op == 1, 8'($urandom_range(0, 255)), n);
      end
    end

    // Reset asserted while the target is driving a 0 data bit.
    wq = '{8'h0F};
    do_write(DEV, 8'h03, 1'b0, -1);
    check_stb("pre_rst");
    i2c_start();
    send_byte({DEV, 1'b0}, a, -1);
    send_byte(8'h03, a, -1);
    i2c_start();
    send_byte({DEV, 1'b1}, a, -1);
    chk("rst_rd_ack", a, 0);
    bit_r(b);
    chk("rst_rd_bit0", b, 1'b0);
    bit_r(b);
    chk("rst_rd_bit1", b, 1'b0);
    chk("rst_pre_sda", sda_bus, 1'b0);
    rst_n = 1'b0;
    #5;
    chk("rst_mid_sda", sda_bus, 1'b1);
    chk("rst_mid_busy", busy_o, 1'b0);
    model_reset();
    chk("rst_mid_regs", regs_o, model_flat());
    #60;
    rst_n = 1'b1;
    #Q;
    i2c_stop();
    stb_rd = stb_n;
    wq = '{8'hC7};
    do_write(DEV, 8'h02, 1'b0, -1);
    check_stb("post_rst");
    do_read(1'b0, 8'h00, 1);

`ifdef I2C_GLITCH_FILTER_EN
    wq = '{8'h5A};
    do_write(DEV, 8'h04, 1'b0, 3);
    check_stb("glitch");
    chk("glitch_reg4", regs_o[39:32], 8'h5A);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
